// File: rtl/lcd16207_responder.sv
// HD44780-compatible panel-side responder for the 16207 LCD bus.
// Holds a 2x40 DDRAM and address counter, answers bus reads and offers a mirror read port.
module lcd16207_responder #(
  parameter int BUSY_CYCLES  = 4000,
  parameter int CLEAR_CYCLES = 153000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FILL = 2'd2,
    ST_BUSY = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 2);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 2);
  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(CLEAR_CYCLES - 81);
  localparam logic FILL_ONLY = (CLEAR_CYCLES <= 80) ? 1'b1 : 1'b0;

  // AC step with the two-line wrap: 0x27<->0x40 and 0x67<->0x00
  function automatic logic [6:0] f_ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == 7'h27)      nxt = 7'h40;
      else if (ac == 7'h67) nxt = 7'h00;
      else                  nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      nxt = 7'h67;
      else if (ac == 7'h40) nxt = 7'h27;
      else                  nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  function automatic logic [6:0] f_ac_lin(input logic [6:0] ac);
    return (ac < 7'h40) ? ac : (ac - 7'd24);
  endfunction

  function automatic logic f_ac_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  logic       r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2, r_en_s1, r_en_s2, r_en_d;
  logic [7:0] r_data_s1, r_data_s2;
  state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0] r_ac, r_fill_idx, w_ac_nxt, w_lin_ac;
  logic       r_id, r_s, r_cgram, r_err, r_cmd_rs, r_cmd_long;
  logic       w_id_nxt, w_s_nxt, w_cgram_nxt, w_mem_we;
  logic [2:0] r_dcb, w_dcb_nxt;
  logic [7:0] r_cmd_data, r_rd_data;
  logic [7:0] r_mem [0:79];
  logic       w_en_fall, w_busy, w_wr_fall, w_rd_fall, w_is_clear, w_bad_addr, w_accept;

  // Two-flop synchronizers on every bus input plus a delayed E for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rs_s1   <= 1'b0;  r_rs_s2   <= 1'b0;
      r_rw_s1   <= 1'b0;  r_rw_s2   <= 1'b0;
      r_en_s1   <= 1'b0;  r_en_s2   <= 1'b0;  r_en_d <= 1'b0;
      r_data_s1 <= 8'h00; r_data_s2 <= 8'h00;
    end else begin
      r_rs_s1   <= lcd_rs;     r_rs_s2   <= r_rs_s1;
      r_rw_s1   <= lcd_rw;     r_rw_s2   <= r_rw_s1;
      r_en_s1   <= lcd_en;     r_en_s2   <= r_en_s1;  r_en_d <= r_en_s2;
      r_data_s1 <= lcd_data_i; r_data_s2 <= r_data_s1;
    end
  end

  assign w_en_fall  = r_en_d & ~r_en_s2;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_wr_fall  = w_en_fall & ~r_rw_s2;
  assign w_rd_fall  = w_en_fall & r_rw_s2;
  assign w_is_clear = ~r_rs_s2 & (r_data_s2 == 8'h01);
  assign w_bad_addr = ~r_rs_s2 & r_data_s2[7] & ~f_ac_valid(r_data_s2[6:0]);
  assign w_accept   = w_wr_fall & ~w_busy & ~w_bad_addr;
  assign w_lin_ac   = f_ac_lin(r_ac);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_is_clear ? ST_FILL : ST_EXEC;
        else          w_state_nxt = ST_IDLE;
      end
      ST_EXEC: w_state_nxt = ST_BUSY;
      ST_FILL: begin
        if (r_fill_idx == 7'd79) w_state_nxt = FILL_ONLY ? ST_IDLE : ST_BUSY;
        else                     w_state_nxt = ST_FILL;
      end
      ST_BUSY: begin
        if (r_cnt == {CNT_W{1'b0}}) w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_BUSY;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Busy countdown; the last load before BUSY sets the remaining length
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_EXEC: r_cnt <= r_cmd_long ? CLEAR_LOAD : BUSY_LOAD;
        ST_FILL: r_cnt <= FILL_LOAD;
        ST_BUSY: if (r_cnt != {CNT_W{1'b0}}) r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Command execution: AC, entry mode, display control, CGRAM mode, DDRAM write strobe
  always_comb begin
    w_ac_nxt    = r_ac;
    w_id_nxt    = r_id;
    w_s_nxt     = r_s;
    w_cgram_nxt = r_cgram;
    w_dcb_nxt   = r_dcb;
    w_mem_we    = 1'b0;
    if (w_accept && w_is_clear) begin
      w_ac_nxt = 7'h00;
      w_id_nxt = 1'b1;
    end else if (r_state == ST_EXEC) begin
      if (r_cmd_rs) begin
        if (!r_cgram) begin
          w_mem_we = 1'b1;
          w_ac_nxt = f_ac_step(r_ac, r_id);
        end else begin
          w_mem_we = 1'b0;
        end
      end else if (r_cmd_data[7]) begin
        w_ac_nxt    = r_cmd_data[6:0];
        w_cgram_nxt = 1'b0;
      end else if (r_cmd_data[6]) begin
        w_cgram_nxt = 1'b1;
      end else if (r_cmd_data[5]) begin
        w_mem_we = 1'b0;
      end else if (r_cmd_data[4]) begin
        if (!r_cmd_data[3]) w_ac_nxt = f_ac_step(r_ac, r_cmd_data[2]);
        else                w_ac_nxt = r_ac;
      end else if (r_cmd_data[3]) begin
        w_dcb_nxt = r_cmd_data[2:0];
      end else if (r_cmd_data[2]) begin
        w_id_nxt = r_cmd_data[1];
        w_s_nxt  = r_cmd_data[0];
      end else if (r_cmd_data[1]) begin
        w_ac_nxt = 7'h00;
      end else begin
        w_mem_we = 1'b0;
      end
    end else if (w_rd_fall && r_rs_s2) begin
      w_ac_nxt = f_ac_step(r_ac, r_id);
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // Control registers, latched command and sticky error
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ac       <= 7'h00;
      r_id       <= 1'b1;
      r_s        <= 1'b0;
      r_cgram    <= 1'b0;
      r_dcb      <= 3'b000;
      r_err      <= 1'b0;
      r_cmd_rs   <= 1'b0;
      r_cmd_data <= 8'h00;
      r_cmd_long <= 1'b0;
      r_fill_idx <= 7'd0;
    end else begin
      r_ac    <= w_ac_nxt;
      r_id    <= w_id_nxt;
      r_s     <= w_s_nxt;
      r_cgram <= w_cgram_nxt;
      r_dcb   <= w_dcb_nxt;
      if (w_wr_fall && (w_busy || w_bad_addr)) r_err <= 1'b1;
      if (w_accept) begin
        r_cmd_rs   <= r_rs_s2;
        r_cmd_data <= r_data_s2;
        r_cmd_long <= ~r_rs_s2 & (r_data_s2[7:1] == 7'b0000001);
      end
      if (w_accept && w_is_clear) r_fill_idx <= 7'd0;
      else if (r_state == ST_FILL) r_fill_idx <= r_fill_idx + 7'd1;
    end
  end

  // DDRAM: FILL sweeps 0x20 one location per cycle, EXEC stores data at AC
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 80; i++) r_mem[i] <= 8'h20;
    end else if (r_state == ST_FILL) begin
      r_mem[r_fill_idx] <= 8'h20;
    end else if (w_mem_we) begin
      r_mem[w_lin_ac] <= r_cmd_data;
    end
  end

  // Mirror read port, reads the pre-write contents on a same-cycle collision
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            r_rd_data <= 8'h00;
    else if (rd_addr > 7'd79)  r_rd_data <= 8'h00;
    else                       r_rd_data <= r_mem[rd_addr];
  end

  // Bus read mux driven only from synchronized strobes
  always_comb begin
    lcd_data_oe = r_en_s2 & r_rw_s2;
    if (!lcd_data_oe) lcd_data_o = 8'h00;
    else if (r_rs_s2) lcd_data_o = r_mem[w_lin_ac];
    else              lcd_data_o = {w_busy, r_ac};
  end

  assign disp_on   = r_dcb[2];
  assign cursor_on = r_dcb[1];
  assign blink_on  = r_dcb[0];
  assign rd_data   = r_rd_data;
  assign cmd_err   = r_err;

endmodule

// File: doc/lcd16207_responder.md
Name: lcd16207_responder

Overview:
Synthesizable HD44780-compatible target for the 16207 LCD bus (RS/RW/E/DATA[7:0]), i.e. the panel end of the interface the LCD controller drives. Decodes controller commands and maintains a 2x40 DDRAM and address counter (AC). Reports busy/AC and DDRAM contents on bus reads, and exposes a mirror read port for an on-chip display or scoreboard. Sits beside the 100 MHz system, same clock as the controller.

Parameters:
BUSY_CYCLES, 4000, busy duration after a normal command/data write (40 us at 100 MHz)
CLEAR_CYCLES, 153000, busy duration after Clear/Home (1.53 ms); must be >= 80

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
lcd_rs  in  1  register select: 0 = instruction/status, 1 = data
lcd_rw  in  1  1 = read, 0 = write
lcd_en  in  1  enable strobe
lcd_data_i  in  8  bus data from controller
lcd_data_o  out  8  bus data to controller during reads
lcd_data_oe  out  1  tri-state enable for lcd_data_o
disp_on  out  1  display-control D bit
cursor_on  out  1  display-control C bit
blink_on  out  1  display-control B bit
rd_addr  in  7  mirror index, 0..79 linear (0..39 line 1, 40..79 line 2)
rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency
cmd_err  out  1  sticky: write while busy, or invalid DDRAM address

Behaviour:
- Reset: all outputs 0; DDRAM all 0x20; AC=0x00; ID=1, S=0; D=C=B=0; busy=0; state IDLE. Reset mid-operation (incl. FILL) aborts immediately.
- Inputs pass 2-FF synchronizers; E edges detected on synchronized E. RS/RW/data sampled on the synchronized E falling edge (write latch point).
- Read: while sync E=1 and RW=1, lcd_data_oe=1 and lcd_data_o = RS=0: {busy, AC}; RS=1: DDRAM[AC]. Reads are allowed while busy. A data read advances AC on E fall; a status read does not.
- Write while busy: ignored, cmd_err set. Otherwise decode by highest set bit:
  0x01 Clear: state FILL, writes 0x20 to one location per cycle for 80 cycles; AC=0, ID=1; busy for CLEAR_CYCLES.
  0x02/0x03 Home: AC=0; busy CLEAR_CYCLES.
  0x04-0x07 Entry mode: ID=d[1], S=d[0] (S stored, no display shift).
  0x08-0x0F Display control: D=d[2], C=d[1], B=d[0].
  0x10-0x1F Shift: S/C=0 moves AC (R/L=1 inc, 0 dec, wrap rules below); S/C=1 no effect.
  0x20-0x3F Function set: accepted, no effect.
  0x40-0x7F CGRAM address: set cgram_mode; subsequent data writes discarded, AC unchanged.
  0x80-0xFF DDRAM address: clears cgram_mode; d[6:0] in 0x00-0x27 or 0x40-0x67 loads AC; else ignored, cmd_err set.
  RS=1 data write: DDRAM[AC]=data, AC advances per ID.
  All non-clear/home accepted writes: busy for BUSY_CYCLES.
- States: IDLE -> EXEC (1 cycle decode/write) -> BUSY (counter down to 0) -> IDLE; Clear: IDLE -> FILL (80 cycles) -> BUSY (remaining CLEAR_CYCLES-80) -> IDLE. busy=1 in EXEC/FILL/BUSY; busy falls exactly BUSY_CYCLES (or CLEAR_CYCLES) cycles after the accepting E fall.
- AC advance: inc 0x27->0x40, 0x67->0x00, else +1; dec 0x00->0x67, 0x40->0x27, else -1.
- Linear index: AC<0x40 -> AC; else AC-0x40+40.
- Mirror port: rd_addr>79 returns 0x00. Same-cycle bus write and mirror read of one location returns the old value.
- cmd_err cleared only by reset.

Test Plan:
- Reset, then status read -> lcd_data_o=0x00, oe=1 only while E high; mirror rd_addr 0..79 all 0x20.
- Write 0x06, 0x80, data 'H','I' -> DDRAM[0]=0x48, [1]=0x49, AC=0x02, busy=1 for 4000 cycles after each E fall.
- Write 0xA7 then data 0x41,0x42 -> AC 0x27->0x40, mirror[39]=0x41, [40]=0x42; then 0x04 and 0x10 from AC=0x00 -> AC=0x67.
- Write 0x0F -> disp_on=cursor_on=blink_on=1; write 0x01 -> busy 153000 cycles, all mirror 0x20, AC=0.
- Data write during busy -> DDRAM unchanged, cmd_err=1; 0xA8 -> AC unchanged, cmd_err=1.
- Assert sys_rst_n low mid-FILL -> all outputs 0 immediately, DDRAM 0x20 after release.
